// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default framing constants
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DBIT       = 8;
  localparam int UART_SB_TICK    = 16;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling baud tick generator: free-running 0..DVSR-1 counter with a
// synchronous clear so a frame can restart the bit timing phase-exactly.
module uart_baud_gen #(
  parameter int DVSR   = 163,
  parameter int DVSR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [DVSR_W-1:0] CNT_MAX = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] cnt_q;
  logic [DVSR_W-1:0] cnt_d;

  // next count: clear wins, otherwise wrap at CNT_MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DVSR_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a TX byte FIFO: pops one word per frame and
// shifts it out LSB first as start / DBIT data / stop.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    S_LAST = 5'(UART_OVERSAMPLE - 1);
  localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [NW-1:0]   n_q, n_d;
  logic [4:0]      s_q, s_d;
  logic            tx_q, tx_d;
  logic            rd_s;
  logic            done_s;
  logic            tick_s;

  // frame start also realigns the baud counter
  uart_baud_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (rd_s),
    .tick (tick_s)
  );

  // next-state, datapath and line level computation
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    n_d     = n_q;
    s_d     = s_q;
    rd_s    = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !rst) begin
          rd_s    = 1'b1;
          b_d     = fifo_rdata;
          s_d     = 5'd0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (s_q == S_LAST) begin
            s_d     = 5'd0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (s_q == S_LAST) begin
            s_d = 5'd0;
            b_d = {1'b0, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (s_q == S_STOP) begin
            done_s  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // line level follows the state being entered so tx changes with it
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      n_q     <= '0;
      s_q     <= 5'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      n_q     <= n_d;
      s_q     <= s_d;
      tx_q    <= tx_d;
    end
  end

  assign fifo_rd      = rd_s;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_s;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench: a queue-based FIFO feeds the transmitter and every
// cycle of each frame is compared with the ideal 8N1 waveform.
module tb_uart_tx_fifo_drain;

  localparam int D   = 4;
  localparam int BIT = 16 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd, tx, tx_busy, tx_done_tick;
  logic       empty32 = 1'b1;
  logic [7:0] rdata32 = 8'h00;
  logic       rd32, tx32, busy32, done32;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  logic [7:0] fifo_q[$];
  logic       pop_now;
  logic [7:0] popped;

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR(D), .DVSR_W(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .DVSR(D), .DVSR_W(8)) dut32 (
    .clk(clk), .rst(rst), .fifo_empty(empty32), .fifo_rdata(rdata32),
    .fifo_rd(rd32), .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pop on a strobe seen at the edge, refresh pins just after
  always @(posedge clk) begin
    pop_now = fifo_rd && !rst;
    #1;
    if (pop_now && fifo_q.size() > 0) popped = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    fifo_rdata = fifo_q[0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {fifo_rd, tx, tx_busy, tx_done_tick} of the selected instance
  function automatic logic [3:0] observe(input bit is32);
    return is32 ? {rd32, tx32, busy32, done32} : {fifo_rd, tx, tx_busy, tx_done_tick};
  endfunction

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k < BIT) return 1'b0;
    else if (k < BIT * 9) return b[(k - BIT) / BIT];
    else return 1'b1;
  endfunction

  // wait for the pop strobe, then check up to 'limit' cycles of the frame
  task automatic check_frame(input logic [7:0] b, input int sb, input bit is32,
                             input int limit, output int unsigned rd_cyc);
    int  len = BIT * 9 + sb * D;
    bit  found = 1'b0;
    logic [3:0] obs;
    rd_cyc = 0;
    for (int w = 0; w < 200 && !found; w++) begin
      @(negedge clk);
      obs = observe(is32);
      if (obs[3]) begin
        found  = 1'b1;
        rd_cyc = cyc;
        chk("rd_pulse", {28'd0, obs}, 32'hC);
      end else begin
        chk("idle", {28'd0, obs}, 32'h4);
      end
    end
    chk("rd_timeout", {31'd0, found}, 32'd1);
    if (!found) return;
    @(posedge clk);
    #1;
    if (is32) empty32 = 1'b1;
    for (int k = 0; k < len && k < limit; k++) begin
      @(negedge clk);
      obs = observe(is32);
      chk($sformatf("frame b=%02h k=%0d", b, k), {28'd0, obs},
          {28'd0, 1'b0, exp_tx(b, k), 1'b1, (k == len - 1)});
    end
  endtask

  initial begin
    int unsigned c0, c1;
    logic [7:0] rb;

    // reset held with data waiting: no pop, line idle
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset", {28'd0, observe(1'b0)}, 32'h4);
    end
    @(posedge clk); #1 rst = 1'b0;

    check_frame(8'hA5, 16, 1'b0, 100000, c0);

    // back-to-back frames
    @(posedge clk); #1;
    push(8'h00);
    push(8'hFF);
    check_frame(8'h00, 16, 1'b0, 100000, c0);
    check_frame(8'hFF, 16, 1'b0, 100000, c1);
    chk("b2b_gap", c1 - c0, 32'd641);

    // empty FIFO stays idle
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      chk("empty", {28'd0, observe(1'b0)}, 32'h4);
    end

    // reset in the middle of data bit 3
    @(posedge clk); #1;
    push(8'h3C);
    check_frame(8'h3C, 16, 1'b0, BIT * 4 + 24, c0);
    @(posedge clk); #1;
    rst = 1'b1;
    rb = 8'($urandom_range(0, 255));
    push(rb);
    @(negedge clk);
    chk("rst_pre_edge_rd", {31'd0, fifo_rd}, 32'd0);
    @(negedge clk);
    chk("rst_mid_frame", {28'd0, observe(1'b0)}, 32'h4);
    @(posedge clk); #1 rst = 1'b0;
    check_frame(rb, 16, 1'b0, 100000, c0);

    // randomized bytes after random idle gaps
    for (int r = 0; r < 3; r++) begin
      rb = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 40)) @(posedge clk);
      @(posedge clk); #1;
      push(rb);
      check_frame(rb, 16, 1'b0, 100000, c0);
    end

    // 2-stop-bit instance
    @(posedge clk); #1;
    empty32 = 1'b0;
    rdata32 = 8'h55;
    check_frame(8'h55, 32, 1'b1, 100000, c0);
    @(negedge clk);
    chk("sb32_idle", {28'd0, observe(1'b1)}, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

UART transmitter that is the read side of the TX byte FIFO. It watches the FIFO's `empty` flag and takes the word on its read-data output (valid combinationally whenever not empty). It pops each word with a one-cycle `rd` pulse and serializes it onto the `tx` line as an 8N1-style frame, using an internal 16× oversampling baud tick. It sits between the TX FIFO and the FPGA pin.

## Interface
Parameters:
- DBIT, 8: data bits per frame
- SB_TICK, 16: stop-bit length in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- DVSR, 163: clocks per oversampling tick; set to f_clk / (16 × baud)
- DVSR_W, 8: width of the baud counter; requires 2^DVSR_W > DVSR−1

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_rdata  in  DBIT  FIFO head word, valid when fifo_empty=0
- fifo_rd  out  1  pop strobe, high for exactly one cycle per byte
- tx  out  1  serial line, registered, idle high
- tx_busy  out  1  high in any state other than IDLE
- tx_done_tick  out  1  one-cycle pulse at the end of each frame's stop bit

## Operation
- FSM states: IDLE, START, DATA, STOP. Registers:
  - b_reg (DBIT): shift register
  - n_reg (ceil log2 DBIT): bit counter
  - s_reg (5 bits): tick counter
  - tx_reg
- IDLE:
  - tx_reg=1.
  - If fifo_empty=0: fifo_rd=1 combinationally this cycle; b_reg←fifo_rdata; s_reg←0; baud counter cleared; next state START.
- START:
  - tx_reg=0.
  - On each tick, s_reg increments. At the tick where s_reg=15: s_reg←0, n_reg←0, go to DATA.
- DATA:
  - tx_reg=b_reg[0], so bits go out LSB first.
  - At the tick where s_reg=15: s_reg←0 and b_reg shifts right by one.
  - If n_reg=DBIT−1, go to STOP; otherwise n_reg increments.
- STOP:
  - tx_reg=1.
  - At the tick where s_reg=SB_TICK−1: tx_done_tick=1 for that cycle; go to IDLE.
- fifo_rd is asserted only in IDLE with fifo_empty=0. It is never asserted while busy, so the block cannot underflow the FIFO.
- Baud generator: a counter that counts 0..DVSR−1 and wraps.
  - tick=1 in the cycle when the count is DVSR−1.
  - Cleared synchronously by the frame-start strobe (same condition as fifo_rd), so frame timing is phase-exact.
- Reset, at any time including mid-frame, at the next clk edge:
  - state=IDLE; tx=1; fifo_rd=0, tx_busy=0, tx_done_tick=0; all counters=0.
  - An already-popped, partly sent byte is discarded.
  - During rst=1, fifo_rd stays 0 even if fifo_empty=0.

## Timing
- Reset values: tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0.
- Latency: if fifo_empty=0 is sampled in IDLE at edge N, fifo_rd is high in the cycle before edge N. tx falls immediately after edge N; tx_busy rises at edge N.
- Bit durations:
  - Start and each data bit: exactly 16·DVSR clocks.
  - Stop bit: SB_TICK·DVSR clocks.
  - Frame: DVSR·(16·(DBIT+1)+SB_TICK) clocks.
- Back-to-back frames: after STOP there is one IDLE cycle, so the stop level lasts SB_TICK·DVSR+1 clocks before the next start bit.
- tx_done_tick and the next fifo_rd are never in the same cycle.

## Structure
- Shared package uart_pkg holds:
  - the state typedef (IDLE, START, DATA, STOP)
  - the default DBIT, SB_TICK and oversampling factor 16, shared with the receiver.
- One sub-module, uart_baud_gen (parameters DVSR, DVSR_W; ports clk, rst, clr, tick), reused by the receiver.
- Everything else is in the top level.

## Test plan
All scenarios use DVSR=4, DBIT=8, SB_TICK=16 (64 clocks per bit, 640 clocks per frame).
- Reset: hold rst for 3 cycles with fifo_empty=0 → fifo_rd=0 throughout; tx=1; tx_busy=0.
- Single byte 0xA5:
  - exactly one fifo_rd pulse;
  - tx reads 0, then 1,0,1,0,0,1,0,1, then 1;
  - each bit lasts 64 clocks;
  - tx_done_tick occurs 640 clocks after tx falls.
- Back-to-back 0x00 then 0xFF from a FIFO holding both:
  - two fifo_rd pulses 641 clocks apart;
  - stop high for 65 clocks between frames;
  - second frame reads 0, then eight 1s, then 1.
- Empty FIFO: hold fifo_empty=1 for 2000 cycles → no fifo_rd; tx stays 1; tx_busy stays 0.
- Reset mid-frame at bit 3 of 0x3C → tx=1 and tx_busy=0 at the next edge. After rst falls with fifo_empty=0, a new frame starts with a full-length 64-clock start bit.
- SB_TICK=32 with byte 0x55 → stop bit lasts 128 clocks; frame lasts 704 clocks.
